// File: rtl/memlog_ctrl_pkg.sv
// Shared types and constants for the MEMLog dump controller.
// Header bytes are only used when MEMLOG_DUMP_HEADER_EN is defined.
package memlog_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_FULL,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX
    } state_t;

    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    // Serializer holds at most one 32-bit word (4 bytes)
    localparam int SER_BYTES_MAX = 4;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/memlog_byte_ser.sv
// Word-to-byte serializer: loads up to 4 bytes and presents them MSB first
// under valid/ready, flagging acceptance of the final byte.
module memlog_byte_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    input  logic        abort,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accept
);

    logic [31:0] sreg;
    logic [2:0]  cnt;
    logic [5:0]  shamt;
    logic        accept;

    // Left-justify the word so its most significant used byte sits at [31:24]
    assign shamt       = {3'(3'd4 - nbytes), 3'b000};
    assign tx_valid    = (cnt != 3'd0);
    assign tx_data     = sreg[31:24];
    assign accept      = tx_valid && tx_ready;
    assign last_accept = accept && (cnt == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (abort) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= word << shamt;
            cnt  <= nbytes;
        end else if (accept) begin
            sreg <= {sreg[23:0], 8'h00};
            cnt  <= cnt - 3'd1;
        end
    end

endmodule

// File: rtl/memlog_dump_ctrl.sv
// MEMLog capture/dump sequencer: arms a capture, then streams every log word
// out as bytes. Optional stream header enabled by `define MEMLOG_DUMP_HEADER_EN.
module memlog_dump_ctrl
    import memlog_ctrl_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int RD_LATENCY      = 1
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_start,
    input  logic                       i_cmd_dump,
    input  logic                       i_abort,
    input  logic                       i_mem_full,
    input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_busy,
    output logic                       o_log_ready,
    output logic                       o_done,
    output logic                       o_cmd_err
);

    localparam int BYTES = bytes_per_word(BRAM_DATA_WIDTH);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_TOP = '1;

`ifdef MEMLOG_DUMP_HEADER_EN
    localparam logic [15:0] HDR_COUNT = 16'((32'd1 << BRAM_ADDR_WIDTH) - 32'd1);
    logic hdr_q, hdr_set, hdr_clr;
`endif

    state_t                     state, state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] addr;
    logic                       addr_clr, addr_inc;
    logic [1:0]                 wait_cnt;
    logic                       wait_last;
    logic                       ser_load, last_acc;
    logic [31:0]                ser_word;
    logic [2:0]                 ser_nbytes;
    logic                       done_nxt, err_nxt;

    assign wait_last = (wait_cnt == 2'(RD_LATENCY - 2));

    always_comb begin
        state_nxt  = state;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        ser_load   = 1'b0;
        ser_word   = 32'(i_data_log_from_mem);
        ser_nbytes = 3'(BYTES);
        done_nxt   = 1'b0;
`ifdef MEMLOG_DUMP_HEADER_EN
        hdr_set    = 1'b0;
        hdr_clr    = 1'b0;
`endif
        case (state)
            ST_IDLE:    if (i_cmd_start) state_nxt = ST_ARM;
            ST_ARM:     state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (i_mem_full) state_nxt = ST_FULL;
            ST_FULL: begin
                if (i_cmd_dump) begin
                    addr_clr = 1'b1;
`ifdef MEMLOG_DUMP_HEADER_EN
                    ser_load   = 1'b1;
                    ser_word   = {HDR_BYTE0, HDR_BYTE1, HDR_COUNT};
                    ser_nbytes = 3'(SER_BYTES_MAX);
                    hdr_set    = 1'b1;
                    state_nxt  = ST_TX;
`else
                    state_nxt = ST_RD_ADDR;
`endif
                end
            end
            // Latch the word on the edge where read data is valid
            ST_RD_ADDR: begin
                if (RD_LATENCY == 1) begin
                    ser_load  = 1'b1;
                    state_nxt = ST_TX;
                end else begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (wait_last) begin
                    ser_load  = 1'b1;
                    state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                if (last_acc) begin
`ifdef MEMLOG_DUMP_HEADER_EN
                    if (hdr_q) begin
                        hdr_clr   = 1'b1;
                        state_nxt = ST_RD_ADDR;
                    end else
`endif
                    if (addr == ADDR_TOP) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        addr_inc  = 1'b1;
                        state_nxt = ST_RD_ADDR;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (i_abort) begin
            state_nxt = ST_IDLE;
            ser_load  = 1'b0;
            addr_inc  = 1'b0;
            done_nxt  = 1'b0;
`ifdef MEMLOG_DUMP_HEADER_EN
            hdr_set   = 1'b0;
            hdr_clr   = 1'b1;
`endif
        end
    end

    // A start and a dump in the same IDLE cycle: start wins, dump is flagged
    assign err_nxt = !i_abort &&
                     ((i_cmd_start && (state != ST_IDLE)) ||
                      (i_cmd_dump  && (state != ST_FULL)));

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            wait_cnt  <= '0;
            o_done    <= 1'b0;
            o_cmd_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_done    <= done_nxt;
            o_cmd_err <= err_nxt;
            if (addr_clr)      addr <= '0;
            else if (addr_inc) addr <= addr + 1'b1;
            if (state == ST_RD_WAIT) wait_cnt <= wait_cnt + 2'd1;
            else                     wait_cnt <= '0;
        end
    end

`ifdef MEMLOG_DUMP_HEADER_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)     hdr_q <= 1'b0;
        else if (hdr_set) hdr_q <= 1'b1;
        else if (hdr_clr) hdr_q <= 1'b0;
    end
`endif

    memlog_byte_ser u_ser (
        .clk         (clk),
        .rst_n       (i_rst_n),
        .load        (ser_load),
        .word        (ser_word),
        .nbytes      (ser_nbytes),
        .abort       (i_abort),
        .tx_ready    (i_tx_ready),
        .tx_data     (o_tx_data),
        .tx_valid    (o_tx_valid),
        .last_accept (last_acc)
    );

    assign o_run_log         = (state == ST_ARM);
    assign o_read_log        = (state == ST_RD_ADDR) && (addr == '0);
    assign o_addr_log_to_mem = addr;
    assign o_busy            = (state != ST_IDLE) && (state != ST_FULL);
    assign o_log_ready       = (state == ST_FULL);

endmodule

// File: tb/tb_memlog_dump_ctrl.sv
// Directed bench for memlog_dump_ctrl with ADDR=3, DATA=16, RD_LATENCY=1 and
// a combinational log memory returning 16'h1000 + addr.
module tb_memlog_dump_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;
`ifdef MEMLOG_DUMP_HEADER_EN
    localparam int HDR_CYC = 4;
`else
    localparam int HDR_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cmd_start = 1'b0, i_cmd_dump = 1'b0, i_abort = 1'b0, i_mem_full = 1'b0;
    logic [DW-1:0] mem_data;
    logic          o_run_log, o_read_log, o_tx_valid, o_busy, o_log_ready, o_done, o_cmd_err;
    logic [AW-1:0] o_addr_log_to_mem;
    logic [7:0]    o_tx_data;
    logic          i_tx_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    memlog_dump_ctrl #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_cmd_start(i_cmd_start), .i_cmd_dump(i_cmd_dump),
        .i_abort(i_abort), .i_mem_full(i_mem_full), .i_data_log_from_mem(mem_data),
        .o_run_log(o_run_log), .o_read_log(o_read_log), .o_addr_log_to_mem(o_addr_log_to_mem),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_log_ready(o_log_ready), .o_done(o_done), .o_cmd_err(o_cmd_err)
    );

    always #5 clk = ~clk;
    assign mem_data = 16'h1000 + {13'd0, o_addr_log_to_mem};

    // Passive monitor: byte capture, handshake stability and pulse counting
    logic [7:0] got[$];
    int   cyc = 0, rd_pulses = 0, done_pulses = 0, stab_err = 0;
    int   last_acc_cyc = 0, done_cyc = 0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_tx_valid && i_tx_ready) begin
            got.push_back(o_tx_data);
            last_acc_cyc <= cyc;
        end
        if (prev_hold && (!o_tx_valid || o_tx_data !== prev_data)) stab_err <= stab_err + 1;
        if (o_read_log) rd_pulses <= rd_pulses + 1;
        if (o_done) begin
            done_pulses <= done_pulses + 1;
            done_cyc    <= cyc;
        end
        prev_hold <= o_tx_valid && !i_tx_ready && i_rst_n && !i_abort;
        prev_data <= o_tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        logic [7:0] exp_q[$];
`ifdef MEMLOG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00); exp_q.push_back(8'h07);
`endif
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back(8'h10);
            exp_q.push_back(8'(w));
        end
        chk({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got.size()) chk($sformatf("%s_b%0d", tag, i), {24'd0, got[base + i]}, {24'd0, exp_q[i]});
    endtask

    task automatic arm_and_fill();
        i_cmd_start = 1'b1; tick(); i_cmd_start = 1'b0;
        tick();
        i_mem_full = 1'b1; tick(); i_mem_full = 1'b0;
    endtask

    initial begin
        int nz, n, base, rd0, dn0;

        // Reset state
        #3;
        chk("rst_outputs", {o_run_log, o_read_log, o_tx_valid, o_busy, o_log_ready, o_done, o_cmd_err},
            32'd0);
        chk("rst_addr", {29'd0, o_addr_log_to_mem}, 32'd0);
        #9 i_rst_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({o_run_log, o_read_log, o_tx_valid, o_busy, o_log_ready, o_done, o_cmd_err} != 0 ||
                o_tx_data != 0 || o_addr_log_to_mem != 0) nz++;
        end
        chk("idle_100_quiet", nz, 0);

        // mem_full ignored in IDLE
        i_mem_full = 1'b1; tick(); i_mem_full = 1'b0;
        chk("full_ignored_idle", {o_log_ready, o_busy}, 2'b00);

        // Start: ARM one cycle, then CAPTURE
        i_cmd_start = 1'b1; tick(); i_cmd_start = 1'b0;
        chk("arm_run_log", {o_run_log, o_busy, o_cmd_err}, 3'b110);
        tick();
        chk("capture", {o_run_log, o_busy, o_log_ready}, 3'b010);

        // Dump in CAPTURE is ignored
        i_cmd_dump = 1'b1; tick(); i_cmd_dump = 1'b0;
        chk("dump_in_capture_err", {o_cmd_err, o_busy, o_log_ready, o_read_log}, 4'b1100);
        tick();
        chk("err_one_cycle", o_cmd_err, 0);

        i_mem_full = 1'b1; tick(); i_mem_full = 1'b0;
        chk("log_ready", {o_log_ready, o_busy}, 2'b10);

        // Start in FULL is ignored
        i_cmd_start = 1'b1; tick(); i_cmd_start = 1'b0;
        chk("start_in_full_err", {o_cmd_err, o_log_ready, o_run_log}, 3'b110);

        // Dump with ready always high
        base = got.size(); rd0 = rd_pulses; dn0 = done_pulses;
        i_cmd_dump = 1'b1; tick(); i_cmd_dump = 1'b0;
`ifdef MEMLOG_DUMP_HEADER_EN
        chk("hdr_first", {o_read_log, o_tx_valid, o_tx_data}, {1'b0, 1'b1, 8'hA5});
`else
        chk("rd_addr0", {o_read_log, o_tx_valid, o_busy}, 3'b101);
        tick();
        chk("first_byte", {o_tx_valid, o_tx_data}, {1'b1, 8'h10});
`endif
        n = 0;
        while (!o_done && n < 200) begin tick(); n++; end
        chk("dump1_done_seen", o_done, 1);
`ifndef MEMLOG_DUMP_HEADER_EN
        n = n + 1;
`endif
        chk("dump1_cycles", n, 24 + HDR_CYC);
        chk("dump1_idle", {o_busy, o_log_ready, o_tx_valid}, 3'b000);
        tick();
        chk("dump1_done_pulse", o_done, 0);
        check_stream("dump1", base);
        chk("dump1_read_log_once", rd_pulses - rd0, 1);
        chk("dump1_done_once", done_pulses - dn0, 1);
        chk("dump1_done_latency", done_cyc - last_acc_cyc, 1);

        // Re-arm after dump, then dump with random ready
        i_cmd_start = 1'b1; tick(); i_cmd_start = 1'b0;
        chk("rearm_run_log", o_run_log, 1);
        tick();
        i_mem_full = 1'b1; tick(); i_mem_full = 1'b0;
        base = got.size(); rd0 = rd_pulses; dn0 = done_pulses;
        i_cmd_dump = 1'b1; tick(); i_cmd_dump = 1'b0;
        n = 0;
        while (!o_done && n < 1000) begin
            i_tx_ready = 1'($urandom_range(0, 1));
            tick(); n++;
        end
        i_tx_ready = 1'b1;
        chk("dump2_done_seen", o_done, 1);
        tick();
        check_stream("dump2", base);
        chk("dump2_stable_hold", stab_err, 0);
        chk("dump2_read_log_once", rd_pulses - rd0, 1);
        chk("dump2_done_once", done_pulses - dn0, 1);

        // Start + dump together in IDLE
        i_cmd_start = 1'b1; i_cmd_dump = 1'b1; tick();
        i_cmd_start = 1'b0; i_cmd_dump = 1'b0;
        chk("start_dump_idle", {o_run_log, o_cmd_err}, 2'b11);
        tick();
        i_mem_full = 1'b1; tick(); i_mem_full = 1'b0;

        // Abort during TX of word 4
        dn0 = done_pulses;
        i_cmd_dump = 1'b1; tick(); i_cmd_dump = 1'b0;
        repeat (13 + HDR_CYC) tick();
        chk("word4_tx", {o_tx_valid, o_tx_data, 5'd0, o_addr_log_to_mem}, {1'b1, 8'h10, 5'd0, 3'd4});
        i_abort = 1'b1; i_tx_ready = 1'b0; tick(); i_abort = 1'b0;
        chk("abort_idle", {o_busy, o_tx_valid, o_log_ready, o_done}, 4'b0000);
        i_tx_ready = 1'b1;
        repeat (5) tick();
        chk("abort_no_done", done_pulses - dn0, 0);

        // Reset mid-dump clears asynchronously and does not resume
        arm_and_fill();
        i_cmd_dump = 1'b1; tick(); i_cmd_dump = 1'b0;
        repeat (4) tick();
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst", {o_busy, o_tx_valid, o_read_log, o_log_ready, 1'b0, o_addr_log_to_mem},
            {4'b0000, 1'b0, 3'd0});
        #3 i_rst_n = 1'b1;
        repeat (5) tick();
        chk("no_resume", {o_busy, o_tx_valid, o_log_ready}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
